instruction_fetch_unit: RTL and testbench

- Front end of the MIPS core. Owns the PC, fetches 32-bit instruction words from instruction memory over a req/ack handshake, and presents each held instruction to decode/control via a valid/ready handshake.
- Drives controlOpcode/lowerOpcode into the main control unit.
- Consumes the control unit's jumpF/jumpRF/branchF flags plus resolved targets to compute the next PC.

---
 rtl/instruction_fetch_unit.sv | 121 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the PC, fetches over req/ack, hands words to decode.
// Optional IFU_PERF_CNT_EN adds instrCount/stallCount outputs.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [31:0] instr,
    output logic [5:0]  controlOpcode,
    output logic [5:0]  lowerOpcode,
    output logic [31:0] pcOut,
    output logic [31:0] pcPlus4,
    input  logic        jumpF,
    input  logic        jumpRF,
    input  logic        branchF,
    input  logic        branchTaken,
    input  logic [31:0] branchOffset,
    input  logic [25:0] jumpTarget,
`ifdef IFU_PERF_CNT_EN
    input  logic [31:0] jumpRegValue,
    output logic [31:0] instrCount,
    output logic [31:0] stallCount
`else
    input  logic [31:0] jumpRegValue
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } stateType;

    stateType    state;
    stateType    nextState;
    logic [31:0] pc;
    logic [31:0] nextPc;
    logic        accept;
    logic        reqQ;
    logic        validQ;

    assign accept = (state == HOLD) && instrReady;

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: nextState = REQ;
            REQ: if (imemAck) nextState = HOLD;
            HOLD: if (instrReady) nextState = REQ;
            default: nextState = IDLE;
        endcase
    end

    // Low PC bits forced to zero on every redirect so fetches stay aligned
    always_comb begin
        nextPc = pcPlus4;
        if (jumpRF) begin
            nextPc = {jumpRegValue[31:2], 2'b00};
        end else if (jumpF) begin
            nextPc = {pcPlus4[31:28], jumpTarget, 2'b00};
        end else if (branchF && branchTaken) begin
            nextPc = pcPlus4 + {branchOffset[29:0], 2'b00};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            instr  <= 32'h0;
            reqQ   <= 1'b0;
            validQ <= 1'b0;
        end else begin
            state  <= nextState;
            reqQ   <= (nextState == REQ);
            validQ <= (nextState == HOLD);
            if ((state == REQ) && imemAck) begin
                instr <= imemData;
            end
            if (accept) begin
                pc <= nextPc;
            end
        end
    end

    assign imemReq       = reqQ;
    assign instrValid    = validQ;
    assign imemAddr      = pc;
    assign pcOut         = pc;
    assign pcPlus4       = pc + 32'd4;
    assign controlOpcode = instr[31:26];
    assign lowerOpcode   = instr[5:0];

`ifdef IFU_PERF_CNT_EN
    logic stallCycle;

    assign stallCycle = ((state == REQ) && !imemAck)
                     || ((state == HOLD) && !instrReady);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instrCount <= 32'h0;
            stallCount <= 32'h0;
        end else begin
            if (accept) begin
                instrCount <= instrCount + 32'd1;
            end
            if (stallCycle) begin
                stallCount <= stallCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed redirects plus random traffic
// checked against a transaction-level PC/memory model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instr;
    logic [5:0]  controlOpcode;
    logic [5:0]  lowerOpcode;
    logic [31:0] pcOut;
    logic [31:0] pcPlus4;
    logic        jumpF;
    logic        jumpRF;
    logic        branchF;
    logic        branchTaken;
    logic [31:0] branchOffset;
    logic [25:0] jumpTarget;
    logic [31:0] jumpRegValue;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] instrCount;
    logic [31:0] stallCount;
`endif

    int          nVec = 0;
    int          nErr = 0;
    logic [31:0] modelPc;
    logic [31:0] expInstr = 0;
    logic [31:0] expStall = 0;

    instruction_fetch_unit #(.RESET_PC(RPC)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .imemReq(imemReq),
        .imemAddr(imemAddr),
        .imemAck(imemAck),
        .imemData(imemData),
        .instrValid(instrValid),
        .instrReady(instrReady),
        .instr(instr),
        .controlOpcode(controlOpcode),
        .lowerOpcode(lowerOpcode),
        .pcOut(pcOut),
        .pcPlus4(pcPlus4),
        .jumpF(jumpF),
        .jumpRF(jumpRF),
        .branchF(branchF),
        .branchTaken(branchTaken),
        .branchOffset(branchOffset),
        .jumpTarget(jumpTarget),
`ifdef IFU_PERF_CNT_EN
        .jumpRegValue(jumpRegValue),
        .instrCount(instrCount),
        .stallCount(stallCount)
`else
        .jumpRegValue(jumpRegValue)
`endif
    );

    always #5 clock = ~clock;

    // Memory contents are a fixed function of the word address
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] refNext(
        input logic [31:0] pc,
        input bit jr, input bit j, input bit b, input bit bt,
        input logic [31:0] off, input logic [25:0] tgt,
        input logic [31:0] rv);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (jr) return rv - (rv % 32'd4);
        if (j) return (seq & 32'hF000_0000) + {6'b0, tgt} * 32'd4;
        if (b && bt) return seq + off * 32'd4;
        return seq;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic randRedirect();
        jumpF        = 1'($urandom);
        jumpRF       = 1'($urandom);
        branchF      = 1'($urandom);
        branchTaken  = 1'($urandom);
        branchOffset = $urandom;
        jumpTarget   = 26'($urandom);
        jumpRegValue = $urandom;
    endtask

    task automatic chkPerf(input string tag);
`ifdef IFU_PERF_CNT_EN
        chk({tag, "_instrCount"}, instrCount, expInstr);
        chk({tag, "_stallCount"}, stallCount, expStall);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    // One full fetch transaction; caller leaves the DUT in its request state
    task automatic fetchOne(input int ackDelay, input int readyDelay,
                            input bit jr, input bit j, input bit b,
                            input bit bt, input logic [31:0] off,
                            input logic [25:0] tgt, input logic [31:0] rv,
                            input int resetAt = -1);
        logic [31:0] w;
        chk("reqAddr", imemAddr, modelPc);
        chk("reqHigh", 32'(imemReq), 32'd1);
        chk("validLowInReq", 32'(instrValid), 32'd0);
        for (int i = 0; i < ackDelay; i++) begin
            imemAck    = 1'b0;
            imemData   = $urandom;
            instrReady = 1'($urandom);
            randRedirect();
            step();
            expStall++;
            chk("waitReq", 32'(imemReq), 32'd1);
            chk("waitAddr", imemAddr, modelPc);
            chk("waitValid", 32'(instrValid), 32'd0);
        end
        w          = memWord(modelPc);
        imemAck    = 1'b1;
        imemData   = w;
        instrReady = 1'($urandom);
        step();
        imemAck  = 1'b0;
        imemData = $urandom;
        chk("holdValid", 32'(instrValid), 32'd1);
        chk("holdReq", 32'(imemReq), 32'd0);
        chk("instr", instr, w);
        chk("ctrlOp", 32'(controlOpcode), 32'(w[31:26]));
        chk("lowOp", 32'(lowerOpcode), 32'(w[5:0]));
        chk("pcOut", pcOut, modelPc);
        chk("pcPlus4", pcPlus4, modelPc + 32'd4);
        for (int i = 0; i < readyDelay; i++) begin
            imemAck    = 1'($urandom);
            imemData   = $urandom;
            instrReady = 1'b0;
            randRedirect();
            if (i == resetAt) begin
                imemAck = 1'b0;
                reset_n = 1'b0;
                #1;
                chk("rstValid", 32'(instrValid), 32'd0);
                chk("rstReq", 32'(imemReq), 32'd0);
                chk("rstAddr", imemAddr, RPC);
                chk("rstInstr", instr, 32'h0);
                expInstr = 0;
                expStall = 0;
                chkPerf("rst");
                step();
                reset_n = 1'b1;
                step();
                modelPc = RPC;
                return;
            end
            step();
            expStall++;
            chk("stallInstr", instr, w);
            chk("stallPc", pcOut, modelPc);
            chk("stallReq", 32'(imemReq), 32'd0);
            chk("stallValid", 32'(instrValid), 32'd1);
        end
        imemAck      = 1'b0;
        instrReady   = 1'b1;
        jumpRF       = jr;
        jumpF        = j;
        branchF      = b;
        branchTaken  = bt;
        branchOffset = off;
        jumpTarget   = tgt;
        jumpRegValue = rv;
        step();
        instrReady = 1'b0;
        randRedirect();
        expInstr++;
        modelPc = refNext(modelPc, jr, j, b, bt, off, tgt, rv);
    endtask

    task automatic plain(input int ad, input int rd);
        fetchOne(ad, rd, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0);
    endtask

    task automatic jrTo(input logic [31:0] target);
        fetchOne(0, 0, 1, 0, 0, 0, 32'h0, 26'h0, target);
    endtask

    initial begin
        reset_n    = 1'b0;
        imemAck    = 1'b0;
        imemData   = 32'h0;
        instrReady = 1'b0;
        randRedirect();
        step();
        step();
        chk("resetReq", 32'(imemReq), 32'd0);
        chk("resetAddr", imemAddr, RPC);
        chk("resetValid", 32'(instrValid), 32'd0);
        chk("resetInstr", instr, 32'h0);
        chkPerf("reset");
        reset_n = 1'b1;
        step();
        modelPc = RPC;

        for (int k = 0; k < 4; k++) begin
            chk("seqAddr", imemAddr, 32'(k * 4));
            plain(0, 0);
        end
        chkPerf("seq");
        chk("ackWaitAddr", imemAddr, 32'h10);
        plain(3, 0);
        chkPerf("ackWait");

        jrTo(32'h100);
        fetchOne(0, 0, 0, 0, 1, 1, 32'hFFFF_FFFE, 26'h0, 32'h0);
        chk("branchTaken", imemAddr, 32'h0000_00FC);
        jrTo(32'h100);
        fetchOne(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFE, 26'h0, 32'h0);
        chk("branchNotTaken", imemAddr, 32'h0000_0104);
        jrTo(32'h4000_0000);
        fetchOne(0, 0, 0, 1, 0, 0, 32'h0, 26'h40, 32'h0);
        chk("jump", imemAddr, 32'h4000_0100);
        jrTo(32'h4000_0000);
        fetchOne(1, 0, 1, 1, 1, 1, 32'h8, 26'h40, 32'h1237);
        chk("jumpReg", imemAddr, 32'h0000_1234);
        jrTo(32'hFFFF_FFFC);
        plain(0, 0);
        chk("wrapAdd", imemAddr, 32'h0);
        fetchOne(0, 0, 0, 0, 1, 1, 32'hFFFF_FFFC, 26'h0, 32'h0);
        chk("wrapBranch", imemAddr, 32'hFFFF_FFF4);
        plain(0, 5);
        chkPerf("stall");
        fetchOne(1, 4, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0, 2);
        chk("afterReset", imemAddr, RPC);
        plain(0, 0);

        for (int n = 0; n < 60; n++) begin
            logic [15:0] imm;
            imm = 16'($urandom);
            fetchOne(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     1'($urandom), 1'($urandom), {{16{imm[15]}}, imm},
                     26'($urandom), $urandom);
        end
        chkPerf("final");

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
